// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction-memory window, PC redirect and the decode handshake.
// The master is the sequencer and the slave is the memory/decode side.
interface fetch_sequencer_if;
  logic [63:0] mem_pc;
  logic [7:0]  mem_byte0;
  logic [71:0] mem_byte19;
  logic        mem_err;
  logic        redir_valid;
  logic [63:0] redir_pc;
  logic        f_ready;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [3:0]  f_icode;
  logic [3:0]  f_ifun;
  logic [3:0]  f_rA;
  logic [3:0]  f_rB;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic [2:0]  f_stat;
  logic        halted;

  modport master (
    output mem_pc,
    input  mem_byte0, mem_byte19, mem_err,
    input  redir_valid, redir_pc, f_ready,
    output f_valid, f_pc, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat, halted
  );

  modport slave (
    input  mem_pc,
    output mem_byte0, mem_byte19, mem_err,
    output redir_valid, redir_pc, f_ready,
    input  f_valid, f_pc, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Y86-64 fetch: drives mem_pc, splits the returned 10-byte window into fields and presents it to decode.
// One instruction per 3 cycles; stalls in VALID while f_ready is low; a redirect restarts fetch.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter logic [63:0] MEM_BYTES = 64'd65536
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.master bus
);
  typedef enum logic [1:0] {S_FETCH, S_CAPTURE, S_VALID, S_HALTED} state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_pc, w_pc_nxt;
  logic        w_capture;

  logic [63:0] r_f_pc, r_f_valC, r_f_valP;
  logic [3:0]  r_f_icode, r_f_ifun, r_f_rA, r_f_rB;
  logic [2:0]  r_f_stat;

  logic [3:0]  w_icode, w_ifun, w_rA, w_rB, w_len;
  logic [63:0] w_valC, w_valP;
  logic [64:0] w_end;
  logic [2:0]  w_stat;
  logic        w_has_regs;

  // Field split of the window returned for r_pc; only consumed in CAPTURE.
  always_comb begin
    w_icode    = bus.mem_byte0[7:4];
    w_ifun     = bus.mem_byte0[3:0];
    w_len      = 4'd1;
    w_has_regs = 1'b0;
    w_valC     = 64'd0;
    case (w_icode)
      4'h2, 4'h6, 4'hA, 4'hB: begin
        w_len      = 4'd2;
        w_has_regs = 1'b1;
      end
      4'h3, 4'h4, 4'h5: begin
        w_len      = 4'd10;
        w_has_regs = 1'b1;
        for (int i = 0; i < 8; i++) w_valC[8*i +: 8] = bus.mem_byte19[63-8*i -: 8];
      end
      4'h7, 4'h8: begin
        w_len = 4'd9;
        for (int i = 0; i < 8; i++) w_valC[8*i +: 8] = bus.mem_byte19[71-8*i -: 8];
      end
      default: ;
    endcase
    w_rA   = w_has_regs ? bus.mem_byte19[71:68] : 4'hF;
    w_rB   = w_has_regs ? bus.mem_byte19[67:64] : 4'hF;
    w_valP = r_pc + 64'(w_len);
    // The end address is compared in 65 bits so a wrapping valP still faults.
    w_end  = {1'b0, r_pc} + 65'(w_len);
    if (bus.mem_err || (w_end > {1'b0, MEM_BYTES})) w_stat = STAT_ADR;
    else if (w_icode >= 4'hC)                       w_stat = STAT_INS;
    else if (w_icode == 4'h0)                       w_stat = STAT_HLT;
    else                                            w_stat = STAT_AOK;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    // A redirect overrides any accept and any pending halt.
    if ((r_state != S_HALTED) && bus.redir_valid) begin
      w_state_nxt = S_FETCH;
      w_pc_nxt    = bus.redir_pc;
    end else begin
      case (r_state)
        S_FETCH:   w_state_nxt = S_CAPTURE;
        S_CAPTURE: begin
          w_state_nxt = S_VALID;
          w_capture   = 1'b1;
        end
        S_VALID: begin
          if (bus.f_ready) begin
            if (r_f_stat == STAT_AOK) begin
              w_state_nxt = S_FETCH;
              w_pc_nxt    = r_f_valP;
            end else begin
              w_state_nxt = S_HALTED;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_pc    <= 64'd0;
      r_f_icode <= 4'h0;
      r_f_ifun  <= 4'h0;
      r_f_rA    <= 4'hF;
      r_f_rB    <= 4'hF;
      r_f_valC  <= 64'd0;
      r_f_valP  <= 64'd0;
      r_f_stat  <= STAT_AOK;
    end else if (w_capture) begin
      r_f_pc    <= r_pc;
      r_f_icode <= w_icode;
      r_f_ifun  <= w_ifun;
      r_f_rA    <= w_rA;
      r_f_rB    <= w_rB;
      r_f_valC  <= w_valC;
      r_f_valP  <= w_valP;
      r_f_stat  <= w_stat;
    end
  end

  assign bus.mem_pc  = r_pc;
  assign bus.f_valid = (r_state == S_VALID);
  assign bus.halted  = (r_state == S_HALTED);
  assign bus.f_pc    = r_f_pc;
  assign bus.f_icode = r_f_icode;
  assign bus.f_ifun  = r_f_ifun;
  assign bus.f_rA    = r_f_rA;
  assign bus.f_rB    = r_f_rB;
  assign bus.f_valC  = r_f_valC;
  assign bus.f_valP  = r_f_valP;
  assign bus.f_stat  = r_f_stat;
endmodule
